// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I instruction fetch stage.
// Holds the PC, fetches one word per instruction over an imem_req/imem_ready
// handshake, presents the word and its decoded fields under a valid/ready
// handshake, and computes the next PC (sequential or redirect) on accept.

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        pc_src,
  input  logic [31:0] imm_ext,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd
);

  // addi x0, x0, 0 -- harmless contents for the instruction register after reset
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    VALID = 2'b10
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_next;
  logic [31:0] instr_next;
  logic [31:0] pc_target;
  logic [31:0] pc_seq;
  logic [31:0] pc_redirect;

  // Word-align an address by clearing its two low bits.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    word_align = {addr[31:2], 2'b00};
  endfunction

  // Candidate next-PC values; both additions wrap modulo 2^32.
  always_comb begin
    pc_seq      = pc + 32'd4;
    pc_redirect = pc + imm_ext;
    if (pc_src) begin
      pc_target = word_align(pc_redirect);
    end else begin
      pc_target = word_align(pc_seq);
    end
  end

  // State, PC and instruction register; reset is asynchronous so a reset in
  // the middle of a fetch drops imem_req and discards any in-flight response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      instr <= NOP;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      instr <= instr_next;
    end
  end

  // Next-state logic: capture the memory word in FETCH, advance the PC only
  // when the consumer accepts in VALID, so no wrong-path fetch is ever issued.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    instr_next = instr;
    case (state)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        if (imem_ready) begin
          instr_next = imem_rdata;
          state_next = VALID;
        end else begin
          state_next = FETCH;
        end
      end
      VALID: begin
        if (instr_ready) begin
          pc_next    = pc_target;
          state_next = FETCH;
        end else begin
          state_next = VALID;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake outputs are pure decodes of the state register, so they are
  // glitch-free and mutually exclusive by construction.
  always_comb begin
    imem_req    = (state == FETCH);
    instr_valid = (state == VALID);
    imem_addr   = pc;
  end

  // Link address and instruction field slices.
  always_comb begin
    pc_plus4 = pc + 32'd4;
    op       = instr[6:0];
    rd       = instr[11:7];
    funct3   = instr[14:12];
    rs1      = instr[19:15];
    rs2      = instr[24:20];
    funct7   = instr[31:25];
  end

  instr_fetch_unit_checker u_checker (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .instr_valid(instr_valid)
  );

endmodule

// instr_fetch_unit_checker: protocol properties of the fetch stage.
module instr_fetch_unit_checker (
  input logic        clk,
  input logic        rst,
  input logic        imem_req,
  input logic [31:0] imem_addr,
  input logic        imem_ready,
  input logic        instr_valid
);

  // Request and valid are never high together.
  req_valid_exclusive: assert property (
    @(posedge clk) disable iff (rst) !(imem_req && instr_valid)
  );

  // A pending request keeps its address until memory answers.
  req_addr_stable: assert property (
    @(posedge clk) disable iff (rst)
      (imem_req && !imem_ready) |=> (imem_req && $stable(imem_addr))
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed self-checking bench for instr_fetch_unit.
// Inputs are driven and outputs sampled on the falling edge; the DUT acts on
// the rising edge. Instance a uses RESET_PC=0, instance b RESET_PC=0xFFFFFFFC.

module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance a signals
  logic        rst;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, pc, pc_plus4;
  logic        imem_ready, instr_ready, pc_src;
  logic [31:0] imem_rdata, imm_ext;
  logic [6:0]  op, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;

  // Instance b signals
  logic        b_rst;
  logic        b_imem_req, b_instr_valid;
  logic [31:0] b_imem_addr, b_instr, b_pc, b_pc_plus4;
  logic        b_imem_ready, b_instr_ready, b_pc_src;
  logic [31:0] b_imem_rdata, b_imm_ext;
  logic [6:0]  b_op, b_funct7;
  logic [2:0]  b_funct3;
  logic [4:0]  b_rs1, b_rs2, b_rd;

  int passed = 0;
  int total  = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc_src(pc_src), .imm_ext(imm_ext), .instr(instr),
    .pc(pc), .pc_plus4(pc_plus4), .op(op), .funct3(funct3), .funct7(funct7),
    .rs1(rs1), .rs2(rs2), .rd(rd)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst(b_rst), .imem_req(b_imem_req), .imem_addr(b_imem_addr),
    .imem_ready(b_imem_ready), .imem_rdata(b_imem_rdata), .instr_valid(b_instr_valid),
    .instr_ready(b_instr_ready), .pc_src(b_pc_src), .imm_ext(b_imm_ext), .instr(b_instr),
    .pc(b_pc), .pc_plus4(b_pc_plus4), .op(b_op), .funct3(b_funct3), .funct7(b_funct7),
    .rs1(b_rs1), .rs2(b_rs2), .rd(b_rd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic mem(input logic rdy, input logic [31:0] data);
    imem_ready = rdy;
    imem_rdata = data;
  endtask

  task automatic accept(input logic rdy, input logic src, input logic [31:0] imm);
    instr_ready = rdy;
    pc_src      = src;
    imm_ext     = imm;
  endtask

  initial begin
    rst = 1'b1; b_rst = 1'b1;
    imem_ready = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0; pc_src = 1'b0; imm_ext = 32'h0;
    b_imem_ready = 1'b0; b_imem_rdata = 32'h0; b_instr_ready = 1'b0; b_pc_src = 1'b0; b_imm_ext = 32'h0;

    // ---- reset values (a) ----
    step(); step();
    chk("rst_pc",    pc, 32'h0);
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_op",    32'(op), 32'h13);

    // ---- release: req low in first cycle, high in second ----
    rst = 1'b0;
    chk("rel_req0", 32'(imem_req), 32'd0);
    mem(1'b1, 32'h0050_0093);
    accept(1'b1, 1'b0, 32'h0);
    step();
    chk("rel_req1",  32'(imem_req), 32'd1);
    chk("rel_addr1", imem_addr, 32'h0);

    // ---- zero-wait stream, sequential ----
    step();
    chk("w0_valid", 32'(instr_valid), 32'd1);
    chk("w0_req",   32'(imem_req), 32'd0);
    chk("w0_instr", instr, 32'h0050_0093);
    chk("w0_pc",    pc, 32'h0);
    chk("w0_op",    32'(op), 32'h13);
    chk("w0_rd",    32'(rd), 32'd1);
    chk("w0_f3",    32'(funct3), 32'd0);
    chk("w0_pc4",   pc_plus4, 32'h4);
    mem(1'b1, 32'h0010_8113);
    step();
    chk("w1_valid0", 32'(instr_valid), 32'd0);
    chk("w1_addr",   imem_addr, 32'h4);
    step();
    chk("w1_valid", 32'(instr_valid), 32'd1);
    chk("w1_pc",    pc, 32'h4);
    chk("w1_rd",    32'(rd), 32'd2);
    chk("w1_rs1",   32'(rs1), 32'd1);
    mem(1'b1, 32'h0020_81B3);
    step();
    chk("w2_addr", imem_addr, 32'h8);
    step();
    chk("w2_valid", 32'(instr_valid), 32'd1);
    chk("w2_pc",    pc, 32'h8);
    chk("w2_op",    32'(op), 32'h33);
    chk("w2_rd",    32'(rd), 32'd3);
    chk("w2_rs2",   32'(rs2), 32'd2);
    chk("w2_f7",    32'(funct7), 32'd0);

    // ---- redirect back to 0x4, then 3 memory wait cycles ----
    accept(1'b1, 1'b1, 32'hFFFF_FFFC);
    mem(1'b0, 32'hDEAD_BEEF);
    step();
    accept(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("wait_req",  32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, 32'h4);
      if (i == 3) mem(1'b1, 32'h4020_8233);
      else mem(1'b0, 32'hDEAD_BEEF);
      step();
    end
    chk("wait_valid", 32'(instr_valid), 32'd1);
    chk("wait_instr", instr, 32'h4020_8233);
    chk("wait_f7",    32'(funct7), 32'h20);
    chk("wait_rd",    32'(rd), 32'd4);

    // ---- backpressure: 5 cycles without accept, memory ready ignored ----
    mem(1'b1, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(instr_valid), 32'd1);
      chk("bp_req",   32'(imem_req), 32'd0);
      chk("bp_instr", instr, 32'h4020_8233);
      chk("bp_pc",    pc, 32'h4);
    end
    accept(1'b1, 1'b1, 32'h0000_000C);
    mem(1'b1, 32'h0000_0063);
    step();
    chk("bp_resume_req",  32'(imem_req), 32'd1);
    chk("bp_resume_addr", imem_addr, 32'h10);

    // ---- branch backward from 0x10 by -8 ----
    accept(1'b0, 1'b0, 32'h0);
    step();
    chk("br_pc", pc, 32'h10);
    accept(1'b1, 1'b1, 32'hFFFF_FFF8);
    mem(1'b1, 32'h0000_0013);
    step();
    chk("br_back_addr", imem_addr, 32'h8);
    step();
    accept(1'b1, 1'b1, 32'h0000_0008);
    step();
    chk("br_fwd_addr", imem_addr, 32'h10);
    step();
    accept(1'b1, 1'b1, 32'h0000_0006);
    step();
    chk("br_odd_addr", imem_addr, 32'h14);

    // ---- instance b: wrap and async reset mid-fetch ----
    chk("b_rst_pc", b_pc, 32'hFFFF_FFFC);
    b_rst = 1'b0;
    b_imem_ready = 1'b1; b_imem_rdata = 32'h0000_0013;
    b_instr_ready = 1'b1; b_pc_src = 1'b0;
    step();
    chk("b_addr0", b_imem_addr, 32'hFFFF_FFFC);
    step();
    chk("b_pc0",  b_pc, 32'hFFFF_FFFC);
    chk("b_pc4",  b_pc_plus4, 32'h0);
    b_imem_ready = 1'b0;
    step();
    chk("b_wrap_addr", b_imem_addr, 32'h0);
    chk("b_wrap_req",  32'(b_imem_req), 32'd1);
    step();
    chk("b_midfetch_req", 32'(b_imem_req), 32'd1);
    #2;
    b_rst = 1'b1;
    #1;
    chk("b_async_req",   32'(b_imem_req), 32'd0);
    chk("b_async_pc",    b_pc, 32'hFFFF_FFFC);
    chk("b_async_instr", b_instr, 32'h0000_0013);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
